// File: rtl/rf_pkg.sv
// Shared definitions for the register-file controller: opcodes,
// register codes, FSM state encoding, data width and a code check.
package rf_pkg;

    localparam int DW = 8;

    localparam logic [1:0] OP_NOP = 2'b00;
    localparam logic [1:0] OP_LDI = 2'b01;
    localparam logic [1:0] OP_MOV = 2'b10;
    localparam logic [1:0] OP_RD  = 2'b11;

    localparam logic [2:0] REG_A = 3'd0;
    localparam logic [2:0] REG_B = 3'd1;
    localparam logic [2:0] REG_C = 3'd2;
    localparam logic [2:0] REG_D = 3'd3;
    localparam logic [2:0] REG_F = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_CAPT  = 3'd2,
        S_WRITE = 3'd3,
        S_RESP  = 3'd4
    } state_t;

    function automatic logic code_ok(input logic [2:0] c);
        return c <= REG_F;
    endfunction

endpackage

// File: rtl/rf_sel_dec.sv
// Register select decoder: 3-bit register code plus enable to one-hot
// selects {A,B,C,D,F} (sel_o[4]=A .. sel_o[0]=F); codes 5-7 give zero.
module rf_sel_dec
    import rf_pkg::*;
(
    input  logic [2:0] code_i,
    input  logic       en_i,
    output logic [4:0] sel_o
);

    always_comb begin
        sel_o = '0;
        if (en_i) begin
            unique case (1'b1)
                (code_i == REG_A): sel_o = 5'b10000;
                (code_i == REG_B): sel_o = 5'b01000;
                (code_i == REG_C): sel_o = 5'b00100;
                (code_i == REG_D): sel_o = 5'b00010;
                (code_i == REG_F): sel_o = 5'b00001;
                default:           sel_o = 5'b00000;
            endcase
        end
    end

endmodule

// File: rtl/rf_ctl.sv
// Register-file controller: accepts NOP/LDI/MOV/RD commands and
// sequences re/we/selects on the register file via a Moore FSM.
// Ports: clk, rst (async active-low), cmd_* handshake in,
// rsp_* handshake out, d/as..fs/re/we to the file, p from the file.
// Optional sticky err output when RF_CTL_ERR_EN is defined.
module rf_ctl
    import rf_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [1:0]    cmd_op,
    input  logic [2:0]    cmd_dst,
    input  logic [2:0]    cmd_src,
    input  logic [DW-1:0] cmd_imm,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_data,
    output logic [DW-1:0] d,
    output logic          as,
    output logic          bs,
    output logic          cs,
    output logic          ds,
    output logic          fs,
    output logic          re,
    output logic          we,
`ifdef RF_CTL_ERR_EN
    output logic          err,
`endif
    input  logic [DW-1:0] p
);

    state_t          state_q, state_d;
    logic [1:0]      op_q;
    logic [2:0]      src_q, dst_q;
    logic [DW-1:0]   hold_q, hold_d;
    logic [DW-1:0]   d_q, rsp_q;
    logic            accept, legal;
    logic            sel_en;
    logic [2:0]      sel_code;
    logic [4:0]      sel;

    assign accept = cmd_valid && (state_q == S_IDLE);

    // Only the fields an op actually uses are range-checked.
    always_comb begin
        legal = 1'b0;
        unique case (cmd_op)
            OP_LDI:  legal = code_ok(cmd_dst);
            OP_MOV:  legal = code_ok(cmd_src) && code_ok(cmd_dst);
            OP_RD:   legal = code_ok(cmd_src);
            default: legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept && legal)
                    state_d = (cmd_op == OP_LDI) ? S_WRITE : S_READ;
            end
            S_READ:  state_d = S_CAPT;
            S_CAPT:  state_d = (op_q == OP_MOV) ? S_WRITE : S_RESP;
            S_WRITE: state_d = S_IDLE;
            S_RESP:  if (rsp_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = (state_q == S_IDLE);
        re        = (state_q == S_READ);
        we        = (state_q == S_WRITE);
        rsp_valid = (state_q == S_RESP);
        sel_en    = re || we;
        sel_code  = re ? src_q : dst_q;
    end

    rf_sel_dec u_dec (
        .code_i (sel_code),
        .en_i   (sel_en),
        .sel_o  (sel)
    );

    assign {as, bs, cs, ds, fs} = sel;
    assign d        = d_q;
    assign rsp_data = rsp_q;

    // Holding register carries the LDI immediate or the captured p.
    always_comb begin
        hold_d = hold_q;
        if (accept && cmd_op == OP_LDI) hold_d = cmd_imm;
        if (state_q == S_CAPT)          hold_d = p;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_q   <= OP_NOP;
            src_q  <= REG_A;
            dst_q  <= REG_A;
            hold_q <= '0;
            d_q    <= '0;
            rsp_q  <= '0;
        end else begin
            if (accept) begin
                op_q  <= cmd_op;
                src_q <= cmd_src;
                dst_q <= cmd_dst;
            end
            hold_q <= hold_d;
            // d and rsp_data only change on entry to WRITE / RESP.
            if (state_d == S_WRITE)
                d_q <= hold_d;
            if (state_q == S_CAPT && state_d == S_RESP)
                rsp_q <= hold_d;
        end
    end

`ifdef RF_CTL_ERR_EN
    logic err_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            err_q <= 1'b0;
        else if (accept && cmd_op != OP_NOP && !legal)
            err_q <= 1'b1;
    end

    assign err = err_q;
`endif

endmodule

// File: tb/tb_rf_ctl.sv
// Directed bench for rf_ctl.
// Small register-file model drives p.
module tb_rf_ctl;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [2:0] cmd_dst;
  logic [2:0] cmd_src;
  logic [7:0] cmd_imm;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_data;
  logic [7:0] d;
  logic       as, bs, cs, ds, fs;
  logic       re, we;
  logic [7:0] p;
`ifdef RF_CTL_ERR_EN
  logic       err;
`endif

  int checks   = 0;
  int failures = 0;

  logic [7:0] mem [5];
  logic [4:0] sels;
  int         idx;

  assign sels = {as, bs, cs, ds, fs};

  always #5 clk = ~clk;

  rf_ctl dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_dst   (cmd_dst),
    .cmd_src   (cmd_src),
    .cmd_imm   (cmd_imm),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .d         (d),
    .as        (as),
    .bs        (bs),
    .cs        (cs),
    .ds        (ds),
    .fs        (fs),
    .re        (re),
    .we        (we),
`ifdef RF_CTL_ERR_EN
    .err       (err),
`endif
    .p         (p)
  );

  always_comb begin
    idx = 0;
    if (bs) idx = 1;
    if (cs) idx = 2;
    if (ds) idx = 3;
    if (fs) idx = 4;
  end

  always @(posedge clk) begin
    if (!rst) begin
      mem[0] <= 8'h00;
      mem[1] <= 8'h00;
      mem[2] <= 8'h00;
      mem[3] <= 8'h00;
      mem[4] <= 8'hC3;
      p      <= 8'h00;
    end else begin
      if (we) mem[idx] <= d;
      if (re) p <= mem[idx];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(
    input string      tag,
    input logic [7:0] obs,
    input logic [7:0] exp
  );
    checks++;
    if (obs !== exp) begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  initial begin
    rst       = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cmd_dst   = 3'd0;
    cmd_src   = 3'd0;
    cmd_imm   = 8'h00;
    rsp_ready = 1'b0;
    repeat (2) tick();

    chk("rst_ready", cmd_ready, 1'b1);
    chk("rst_re", re, 1'b0);
    chk("rst_we", we, 1'b0);
    chk("rst_sel", sels, 5'b00000);
    chk("rst_rspv", rsp_valid, 1'b0);
    chk("rst_d", d, 8'h00);
    chk("rst_rspd", rsp_data, 8'h00);
`ifdef RF_CTL_ERR_EN
    chk("rst_err", err, 1'b0);
`endif
    rst = 1'b1;
    tick();

    cmd_valid = 1'b1; cmd_op = 2'b01;
    cmd_dst = 3'd1; cmd_imm = 8'h5A;
    tick();
    cmd_valid = 1'b0; cmd_imm = 8'hFF;
    cmd_dst = 3'd2;
    chk("ldi_we", we, 1'b1);
    chk("ldi_re", re, 1'b0);
    chk("ldi_sel", sels, 5'b01000);
    chk("ldi_d", d, 8'h5A);
    chk("ldi_busy", cmd_ready, 1'b0);
    tick();
    chk("ldi_done_we", we, 1'b0);
    chk("ldi_done_rdy", cmd_ready, 1'b1);
    chk("ldi_d_hold", d, 8'h5A);

    cmd_valid = 1'b1; cmd_op = 2'b10;
    cmd_src = 3'd1; cmd_dst = 3'd3;
    tick();
    cmd_valid = 1'b0; cmd_src = 3'd0;
    cmd_dst = 3'd0;
    chk("mov_rd_re", re, 1'b1);
    chk("mov_rd_we", we, 1'b0);
    chk("mov_rd_sel", sels, 5'b01000);
    tick();
    chk("mov_capt_sel", sels, 5'b00000);
    chk("mov_capt_rewe", {re, we}, 2'b00);
    tick();
    chk("mov_wr_we", we, 1'b1);
    chk("mov_wr_sel", sels, 5'b00010);
    chk("mov_wr_d", d, 8'h5A);
    tick();
    chk("mov_idle", cmd_ready, 1'b1);
    chk("mov_idle_we", we, 1'b0);

    cmd_valid = 1'b1; cmd_op = 2'b11;
    cmd_src = 3'd4;
    tick();
    cmd_valid = 1'b0; cmd_src = 3'd0;
    chk("rd_re", re, 1'b1);
    chk("rd_sel", sels, 5'b00001);
    tick();
    chk("rd_capt_rspv", rsp_valid, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rd_rspv", rsp_valid, 1'b1);
      chk("rd_rspd", rsp_data, 8'hC3);
      chk("rd_busy", cmd_ready, 1'b0);
      chk("rd_sel_off", sels, 5'b00000);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("rd_done_rspv", rsp_valid, 1'b0);
    chk("rd_done_rdy", cmd_ready, 1'b1);
    chk("rd_rspd_hold", rsp_data, 8'hC3);

    cmd_valid = 1'b1; cmd_op = 2'b01;
    cmd_dst = 3'd6; cmd_imm = 8'h77;
    tick();
    cmd_valid = 1'b0;
    chk("ill_we", we, 1'b0);
    chk("ill_rdy", cmd_ready, 1'b1);
`ifdef RF_CTL_ERR_EN
    chk("ill_err", err, 1'b1);
`endif
    tick();
    chk("ill_we2", we, 1'b0);
    chk("ill_d_hold", d, 8'h5A);

    cmd_valid = 1'b1; cmd_op = 2'b01;
    cmd_dst = 3'd0; cmd_imm = 8'h11;
    tick();
    cmd_valid = 1'b0;
    chk("ldia_we", we, 1'b1);
    chk("ldia_sel", sels, 5'b10000);
    chk("ldia_d", d, 8'h11);
`ifdef RF_CTL_ERR_EN
    chk("err_sticky", err, 1'b1);
`endif
    tick();

    cmd_valid = 1'b1; cmd_op = 2'b10;
    cmd_src = 3'd3; cmd_dst = 3'd2;
    tick();
    cmd_valid = 1'b0;
    chk("rmov_re", re, 1'b1);
    tick();
    chk("rmov_capt", {re, we}, 2'b00);
    rst = 1'b0;
    #1;
    chk("rmov_rewe", {re, we}, 2'b00);
    chk("rmov_sel", sels, 5'b00000);
    chk("rmov_rdy", cmd_ready, 1'b1);
    chk("rmov_d", d, 8'h00);
    chk("rmov_rspd", rsp_data, 8'h00);
`ifdef RF_CTL_ERR_EN
    chk("rmov_err", err, 1'b0);
`endif
    tick();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rmov_no_we", we, 1'b0);
      chk("rmov_no_re", re, 1'b0);
    end

    cmd_valid = 1'b1; cmd_op = 2'b01;
    cmd_dst = 3'd2; cmd_imm = 8'hA1;
    tick();
    cmd_imm = 8'hB2; cmd_dst = 3'd3;
    chk("b2b_we1", we, 1'b1);
    chk("b2b_d1", d, 8'hA1);
    chk("b2b_sel1", sels, 5'b00100);
    tick();
    chk("b2b_gap_we", we, 1'b0);
    chk("b2b_gap_rdy", cmd_ready, 1'b1);
    tick();
    cmd_valid = 1'b0;
    chk("b2b_we2", we, 1'b1);
    chk("b2b_d2", d, 8'hB2);
    chk("b2b_sel2", sels, 5'b00010);
    tick();
    chk("b2b_end_we", we, 1'b0);
    chk("b2b_end_rdy", cmd_ready, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
